// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin front end that shares one shift-add multiplier
// between two requesters. It latches the winner's operands, pulses the
// multiplier start, waits for done (bounded by a watchdog), and returns the
// product to the requester that owns the transaction. Every output is a
// register, so nothing downstream sees a combinational path from the inputs.
//
// TIMEOUT must be within 2..255 because the watchdog counter is 8 bits wide.

module mult_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        Clk,
  input  logic        Rst,

  input  logic        Req0,
  input  logic [15:0] A0,
  input  logic [15:0] B0,
  output logic        Gnt0,
  output logic        Rdy0,
  output logic [31:0] P0,

  input  logic        Req1,
  input  logic [15:0] A1,
  input  logic [15:0] B1,
  output logic        Gnt1,
  output logic        Rdy1,
  output logic [31:0] P1,

  output logic        Mul_St,
  output logic [15:0] Mul_Multiplicando,
  output logic [15:0] Mul_Multiplicador,
  input  logic        Mul_Idle,
  input  logic        Mul_Done,
  input  logic [31:0] Mul_Produto,

  output logic        Err
);

  // Last counter value that is still a legal WAIT cycle. Reaching it without
  // a done means the multiplier is considered hung.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_t;

  state_t      state_q, state_d;

  // rr_q remembers the last winner; on a tie the other port is chosen.
  logic        rr_q, rr_d;
  logic        owner_q, owner_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [15:0] opA_q, opA_d;
  logic [15:0] opB_q, opB_d;
  logic        mulSt_q, mulSt_d;

  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        rdy0_q, rdy0_d;
  logic        rdy1_q, rdy1_d;
  logic [31:0] p0_q, p0_d;
  logic [31:0] p1_q, p1_d;
  logic        err_q, err_d;

  logic        anyReq;
  logic        winner;
  logic        launch;

  // Pick the port that would be granted if the FSM started a transaction now.
  always_comb begin
    anyReq = Req0 | Req1;
    winner = 1'b0;
    if (Req0 && Req1) begin
      winner = ~rr_q;
    end else if (Req1) begin
      winner = 1'b1;
    end
    launch = anyReq & Mul_Idle;
  end

  // Next-state and next-output logic; pulses default low, data registers hold.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    err_d   = err_q;
    mulSt_d = 1'b0;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    rdy0_d  = 1'b0;
    rdy1_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Only leave IDLE when the multiplier can actually accept work, so a
        // start pulse is never issued into a busy unit.
        if (launch) begin
          opA_d   = winner ? A1 : A0;
          opB_d   = winner ? B1 : B0;
          owner_d = winner;
          rr_d    = winner;
          mulSt_d = 1'b1;
          gnt0_d  = ~winner;
          gnt1_d  = winner;
          state_d = StStart;
        end
      end

      StStart: begin
        // Start and grant are visible for exactly this one cycle.
        cnt_d   = 8'd0;
        state_d = StWait;
      end

      StWait: begin
        cnt_d = cnt_q + 8'd1;
        // A done in the same cycle as the timeout still delivers the result.
        if (Mul_Done) begin
          if (owner_q) begin
            p1_d   = Mul_Produto;
            rdy1_d = 1'b1;
          end else begin
            p0_d   = Mul_Produto;
            rdy0_d = 1'b1;
          end
          state_d = StDone;
        end else if (cnt_q == TimeoutLast) begin
          if (owner_q) begin
            p1_d   = 32'd0;
            rdy1_d = 1'b1;
          end else begin
            p0_d   = 32'd0;
            rdy0_d = 1'b1;
          end
          err_d   = 1'b1;
          state_d = StDone;
        end
      end

      StDone: begin
        // Ready pulse is on the outputs during this cycle; go back to arbitrate.
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset clears everything and points the
  // round-robin at port 1 so that port 0 wins the first tie.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= StIdle;
      rr_q    <= 1'b1;
      owner_q <= 1'b0;
      cnt_q   <= 8'd0;
      opA_q   <= 16'd0;
      opB_q   <= 16'd0;
      mulSt_q <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      rdy0_q  <= 1'b0;
      rdy1_q  <= 1'b0;
      p0_q    <= 32'd0;
      p1_q    <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      mulSt_q <= mulSt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      rdy0_q  <= rdy0_d;
      rdy1_q  <= rdy1_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      err_q   <= err_d;
    end
  end

  assign Gnt0              = gnt0_q;
  assign Gnt1              = gnt1_q;
  assign Rdy0              = rdy0_q;
  assign Rdy1              = rdy1_q;
  assign P0                = p0_q;
  assign P1                = p1_q;
  assign Mul_St            = mulSt_q;
  assign Mul_Multiplicando = opA_q;
  assign Mul_Multiplicador = opB_q;
  assign Err               = err_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed scenarios for mult_arbiter against a simple
// behavioural multiplier with fixed latency and a hang switch.

module tb_mult_arbiter;

  localparam int TO     = 8;
  localparam int MulLat = 4;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Req0, Req1;
  logic [15:0] A0, B0, A1, B1;
  logic        Gnt0, Rdy0, Gnt1, Rdy1;
  logic [31:0] P0, P1;
  logic        Mul_St;
  logic [15:0] Mul_Multiplicando, Mul_Multiplicador;
  logic        Mul_Idle, Mul_Done;
  logic [31:0] Mul_Produto;
  logic        Err;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  mult_arbiter #(.TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst),
    .Req0(Req0), .A0(A0), .B0(B0), .Gnt0(Gnt0), .Rdy0(Rdy0), .P0(P0),
    .Req1(Req1), .A1(A1), .B1(B1), .Gnt1(Gnt1), .Rdy1(Rdy1), .P1(P1),
    .Mul_St(Mul_St), .Mul_Multiplicando(Mul_Multiplicando),
    .Mul_Multiplicador(Mul_Multiplicador), .Mul_Idle(Mul_Idle),
    .Mul_Done(Mul_Done), .Mul_Produto(Mul_Produto), .Err(Err)
  );

  // Behavioural multiplier: accepts a start when idle, answers MulLat cycles later.
  logic        mulBusy;
  logic [3:0]  mulCnt;
  logic [31:0] mulProd;
  bit          mulHang = 1'b0;

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      mulBusy     <= 1'b0;
      mulCnt      <= 4'd0;
      mulProd     <= 32'd0;
      Mul_Done    <= 1'b0;
      Mul_Idle    <= 1'b1;
      Mul_Produto <= 32'hDEADBEEF;
    end else begin
      Mul_Done <= 1'b0;
      if (Mul_St && !mulBusy) begin
        mulBusy  <= 1'b1;
        Mul_Idle <= 1'b0;
        mulCnt   <= 4'(MulLat);
        mulProd  <= {16'd0, Mul_Multiplicando} * {16'd0, Mul_Multiplicador};
      end else if (mulBusy && !mulHang) begin
        if (mulCnt == 4'd1) begin
          Mul_Done    <= 1'b1;
          Mul_Produto <= mulProd;
          mulBusy     <= 1'b0;
          Mul_Idle    <= 1'b1;
        end else begin
          mulCnt <= mulCnt - 4'd1;
        end
      end
    end
  end

  // Passive monitor of grants, starts and ready pulses.
  int stCount = 0, stBusy = 0, dualGnt = 0, rdy0Count = 0, rdy1Count = 0;
  int gntLog[$];

  always @(negedge Clk) begin
    if (Gnt0 && Gnt1) dualGnt++;
    if (Gnt0) gntLog.push_back(0);
    if (Gnt1) gntLog.push_back(1);
    if (Mul_St) stCount++;
    if (Mul_St && !Mul_Idle) stBusy++;
    if (Rdy0) rdy0Count++;
    if (Rdy1) rdy1Count++;
  end

  task automatic waitRdy(input int port, input int maxCyc, output int cycles,
                         output bit seen, output bit doneBefore);
    logic pd;
    cycles = 0;
    seen = 1'b0;
    doneBefore = 1'b0;
    while (!seen && cycles < maxCyc) begin
      pd = Mul_Done;
      @(negedge Clk);
      cycles++;
      if ((port == 0 && Rdy0) || (port == 1 && Rdy1)) begin
        seen = 1'b1;
        doneBefore = pd;
      end
    end
  endtask

  task automatic waitGnt(input int port, input int maxCyc, output bit seen);
    int cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < maxCyc) begin
      @(negedge Clk);
      cycles++;
      if ((port == 0 && Gnt0) || (port == 1 && Gnt1)) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    Rst = 1'b0; Req0 = 1'b0; Req1 = 1'b0;
    A0 = 16'd0; B0 = 16'd0; A1 = 16'd0; B1 = 16'd0;
    repeat (2) @(negedge Clk);
    checks++;
    if ({Gnt0, Gnt1, Rdy0, Rdy1, Mul_St, Err} !== 6'd0) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b expected 000000", {Gnt0, Gnt1, Rdy0, Rdy1, Mul_St, Err});
    end
    checks++;
    if ({P0, P1} !== 64'd0) begin
      failures++;
      $display("[TB] FAIL reset_products: got %h expected 0", {P0, P1});
    end
    checks++;
    if ({Mul_Multiplicando, Mul_Multiplicador} !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_operands: got %h expected 0", {Mul_Multiplicando, Mul_Multiplicador});
    end
    Rst = 1'b1;
    @(negedge Clk);
    checks++;
    if ({Gnt0, Gnt1, Mul_St} !== 3'd0) begin
      failures++;
      $display("[TB] FAIL idle_no_req: got %b expected 000", {Gnt0, Gnt1, Mul_St});
    end
  endtask

  task automatic test_single;
    int s0 = stCount, r1 = rdy1Count, cyc;
    bit seen, db;
    Req0 = 1'b1; A0 = 16'd13; B0 = 16'd11;
    @(negedge Clk);
    checks++;
    if ({Gnt0, Gnt1, Mul_St} !== 3'b101) begin
      failures++;
      $display("[TB] FAIL single_gnt: got %b expected 101", {Gnt0, Gnt1, Mul_St});
    end
    checks++;
    if ({Mul_Multiplicando, Mul_Multiplicador} !== {16'd13, 16'd11}) begin
      failures++;
      $display("[TB] FAIL single_operands: got %h expected 000d000b", {Mul_Multiplicando, Mul_Multiplicador});
    end
    A0 = 16'd99; B0 = 16'd99;
    @(negedge Clk);
    checks++;
    if ({Gnt0, Mul_St} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL single_pulse_width: got %b expected 00", {Gnt0, Mul_St});
    end
    waitRdy(0, 50, cyc, seen, db);
    checks++;
    if (!seen || !db) begin
      failures++;
      $display("[TB] FAIL single_rdy_timing: seen=%0d done_prev=%0d expected 1 1", seen, db);
    end
    checks++;
    if (P0 !== 32'd143) begin
      failures++;
      $display("[TB] FAIL single_p0: got %0d expected 143", P0);
    end
    Req0 = 1'b0;
    @(negedge Clk);
    checks++;
    if (Rdy0 !== 1'b0 || P0 !== 32'd143) begin
      failures++;
      $display("[TB] FAIL single_rdy_hold: rdy=%b p0=%0d expected 0 143", Rdy0, P0);
    end
    repeat (2) @(negedge Clk);
    checks++;
    if (stCount - s0 !== 1) begin
      failures++;
      $display("[TB] FAIL single_st_count: got %0d expected 1", stCount - s0);
    end
    checks++;
    if (P1 !== 32'd0 || rdy1Count != r1 || Err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_port1_quiet: p1=%0d rdy1=%0d err=%b expected 0 0 0", P1, rdy1Count - r1, Err);
    end
  endtask

  task automatic test_both;
    int g, d, cyc, order;
    bit seen, db;
    Rst = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    g = gntLog.size(); d = dualGnt;
    Req0 = 1'b1; A0 = 16'd4001; B0 = 16'd2001;
    Req1 = 1'b1; A1 = 16'd13;   B1 = 16'd11;
    waitRdy(0, 50, cyc, seen, db);
    checks++;
    if (!seen || P0 !== 32'd8006001) begin
      failures++;
      $display("[TB] FAIL both_p0: seen=%0d got %0d expected 8006001", seen, P0);
    end
    Req0 = 1'b0;
    waitRdy(1, 50, cyc, seen, db);
    checks++;
    if (!seen || P1 !== 32'd143) begin
      failures++;
      $display("[TB] FAIL both_p1: seen=%0d got %0d expected 143", seen, P1);
    end
    Req1 = 1'b0;
    @(negedge Clk);
    order = 0;
    for (int i = g; i < gntLog.size(); i++) order = order * 10 + gntLog[i] + 1;
    checks++;
    if (order !== 12) begin
      failures++;
      $display("[TB] FAIL both_order: got code %0d expected 12 (port0 then port1)", order);
    end
    checks++;
    if (dualGnt - d !== 0) begin
      failures++;
      $display("[TB] FAIL both_dual_gnt: got %0d expected 0", dualGnt - d);
    end
  endtask

  task automatic test_fairness;
    int g = gntLog.size(), s = stCount, b = stBusy, nRdy = 0, cyc = 0, order;
    Req0 = 1'b1; A0 = 16'd3; B0 = 16'd5;
    Req1 = 1'b1; A1 = 16'd7; B1 = 16'd9;
    while (nRdy < 4 && cyc < 400) begin
      @(negedge Clk);
      cyc++;
      if (Rdy0 || Rdy1) nRdy++;
    end
    Req0 = 1'b0; Req1 = 1'b0;
    @(negedge Clk);
    checks++;
    if (nRdy !== 4) begin
      failures++;
      $display("[TB] FAIL fair_rdy_count: got %0d expected 4", nRdy);
    end
    order = 0;
    for (int i = g; i < gntLog.size(); i++) order = order * 10 + gntLog[i] + 1;
    checks++;
    if (order !== 1212) begin
      failures++;
      $display("[TB] FAIL fair_order: got code %0d expected 1212 (0,1,0,1)", order);
    end
    checks++;
    if (P0 !== 32'd15 || P1 !== 32'd63) begin
      failures++;
      $display("[TB] FAIL fair_products: got %0d %0d expected 15 63", P0, P1);
    end
    checks++;
    if (stCount - s !== 4 || stBusy - b !== 0) begin
      failures++;
      $display("[TB] FAIL fair_starts: starts=%0d busy_starts=%0d expected 4 0", stCount - s, stBusy - b);
    end
  endtask

  task automatic test_max;
    int cyc;
    bit seen, db;
    Req1 = 1'b1; A1 = 16'hFFFF; B1 = 16'hFFFF;
    waitRdy(1, 50, cyc, seen, db);
    checks++;
    if (!seen || P1 !== 32'hFFFE0001) begin
      failures++;
      $display("[TB] FAIL max_p1: seen=%0d got %h expected fffe0001", seen, P1);
    end
    Req1 = 1'b0;
    @(negedge Clk);
    checks++;
    if (P0 !== 32'd15) begin
      failures++;
      $display("[TB] FAIL max_p0_hold: got %0d expected 15", P0);
    end
  endtask

  task automatic test_timeout;
    int r0 = rdy0Count, cyc;
    bit seen, db;
    mulHang = 1'b1;
    Req0 = 1'b1; A0 = 16'd2; B0 = 16'd3;
    waitGnt(0, 20, seen);
    checks++;
    if (!seen || Err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL to_gnt: seen=%0d err=%b expected 1 0", seen, Err);
    end
    waitRdy(0, 100, cyc, seen, db);
    checks++;
    if (!seen || cyc !== TO + 1) begin
      failures++;
      $display("[TB] FAIL to_latency: seen=%0d cycles=%0d expected 1 %0d", seen, cyc, TO + 1);
    end
    checks++;
    if (P0 !== 32'd0 || Err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL to_result: p0=%0d err=%b expected 0 1", P0, Err);
    end
    Req0 = 1'b0;
    mulHang = 1'b0;
    Req1 = 1'b1; A1 = 16'd6; B1 = 16'd7;
    waitRdy(1, 100, cyc, seen, db);
    checks++;
    if (!seen || P1 !== 32'd42 || Err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL to_recover: seen=%0d p1=%0d err=%b expected 1 42 1", seen, P1, Err);
    end
    Req1 = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if (rdy0Count - r0 !== 1) begin
      failures++;
      $display("[TB] FAIL to_stray_done: rdy0 pulses=%0d expected 1", rdy0Count - r0);
    end
  endtask

  task automatic test_reset_mid;
    int r0, cyc;
    bit seen, db;
    Req0 = 1'b1; A0 = 16'd5; B0 = 16'd5;
    waitGnt(0, 20, seen);
    repeat (2) @(negedge Clk);
    r0 = rdy0Count;
    #2 Rst = 1'b0;
    #1;
    checks++;
    if ({Gnt0, Gnt1, Rdy0, Rdy1, Mul_St, Err} !== 6'd0) begin
      failures++;
      $display("[TB] FAIL mid_reset_flags: got %b expected 000000", {Gnt0, Gnt1, Rdy0, Rdy1, Mul_St, Err});
    end
    checks++;
    if ({P0, P1, Mul_Multiplicando, Mul_Multiplicador} !== 96'd0) begin
      failures++;
      $display("[TB] FAIL mid_reset_data: got %h expected 0", {P0, P1, Mul_Multiplicando, Mul_Multiplicador});
    end
    Req0 = 1'b0;
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    Req1 = 1'b1; A1 = 16'd9; B1 = 16'd9;
    @(negedge Clk);
    checks++;
    if ({Gnt0, Gnt1, Mul_St} !== 3'b011) begin
      failures++;
      $display("[TB] FAIL mid_regrant: got %b expected 011", {Gnt0, Gnt1, Mul_St});
    end
    waitRdy(1, 50, cyc, seen, db);
    checks++;
    if (!seen || P1 !== 32'd81) begin
      failures++;
      $display("[TB] FAIL mid_p1: seen=%0d got %0d expected 81", seen, P1);
    end
    Req1 = 1'b0;
    @(negedge Clk);
    checks++;
    if (rdy0Count - r0 !== 0) begin
      failures++;
      $display("[TB] FAIL mid_no_rdy0: got %0d pulses expected 0", rdy0Count - r0);
    end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_single();
    test_both();
    test_fairness();
    test_max();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound on total simulation time.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] aborted");
  end

endmodule
